// File: rtl/rs485_pkg.sv
// Shared types and defaults for the RS485 frame echo block.
// Default gap/turnaround values assume a 16x oversample clock at 9600 baud.
package rs485_pkg;

  // Control FSM encoding; exported on the debug port of the top level.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RECV      = 3'd1,
    ST_TURN      = 3'd2,
    ST_LOAD      = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_BUSY = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_t;

  // 3.5 character times at 16 ticks per bit, 10 bits per character.
  localparam int DEF_GAP_TICKS  = 560;
  // Half-duplex bus turnaround before the first echoed byte.
  localparam int DEF_TURN_TICKS = 32;
  // Counter width; must hold max(GAP_TICKS, TURN_TICKS).
  localparam int DEF_GAP_W      = 12;

endpackage

// File: rtl/rs485_frame_echo_if.sv
// Byte-level link between the echo controller and the rs485_rx/rs485_tx PHYs.
//
// Handshake semantics:
//   rx side : rs485_rx_valid is a one-cycle strobe; rs485_rx_data is only
//             meaningful in that cycle. There is no back-pressure.
//   tx side : rs485_tx_idle acts as "ready". A character is transferred when
//             rs485_tx_en is high for one cycle while rs485_tx_idle was high on
//             the cycle the request was issued. rs485_tx_data is held stable
//             from the cycle before rs485_tx_en until the next load.
interface rs485_frame_echo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rs485_rx_data;
  logic              rs485_rx_valid;
  logic              rs485_tx_idle;
  logic [DATA_W-1:0] rs485_tx_data;
  logic              rs485_tx_en;

  // Echo controller side.
  modport master (
    input  rs485_rx_data,
    input  rs485_rx_valid,
    input  rs485_tx_idle,
    output rs485_tx_data,
    output rs485_tx_en
  );

  // PHY side (receiver drives data/valid, transmitter reports idle).
  modport slave (
    output rs485_rx_data,
    output rs485_rx_valid,
    output rs485_tx_idle,
    input  rs485_tx_data,
    input  rs485_tx_en
  );
endinterface

// File: rtl/rs485_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// both on clk. Contents are intentionally not reset.
module rs485_frame_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port (one-cycle read latency).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rs485_frame_echo.sv
// RS485 frame echo: buffers one received frame, closes it after an idle gap,
// waits a bus turnaround time, then replays it through the transmitter.
module rs485_frame_echo
  import rs485_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int TURN_TICKS = DEF_TURN_TICKS,
  parameter int GAP_W      = DEF_GAP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  rs485_frame_echo_if.master bus,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_done,
  output logic              overflow,
  output logic              collision,
  output logic              busy,
  output state_t            state_dbg
);

  // DEPTH expressed in the ADDR_W+1 bit counter domain.
  localparam logic [ADDR_W:0] DEPTH_V   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [GAP_W-1:0] TURN_LAST = GAP_W'(TURN_TICKS - 1);

  state_t            state, state_d;
  logic [ADDR_W:0]   cnt, cnt_d;
  logic [ADDR_W:0]   rptr, rptr_d;
  logic [GAP_W-1:0]  gap, gap_d;
  logic [GAP_W-1:0]  tcnt, tcnt_d;
  logic [ADDR_W:0]   len_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              done_d, ov_d, col_d;
  logic              ld_wait, ld_wait_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_rdata;

  // The read address follows rptr continuously; LOAD spends one cycle
  // letting the registered read settle before capturing it.
  rs485_frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.rs485_rx_data),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    rptr_d    = rptr;
    gap_d     = gap;
    tcnt_d    = tcnt;
    len_d     = frame_len;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    done_d    = 1'b0;
    ov_d      = overflow;
    col_d     = collision;
    ld_wait_d = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cnt[ADDR_W-1:0];

    case (state)
      ST_IDLE: begin
        if (bus.rs485_rx_valid) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          cnt_d     = {{ADDR_W{1'b0}}, 1'b1};
          gap_d     = '0;
          ov_d      = 1'b0;
          col_d     = 1'b0;
          state_d   = ST_RECV;
        end
      end
      ST_RECV: begin
        // A byte on the closing cycle wins: the frame stays open.
        if (bus.rs485_rx_valid) begin
          gap_d = '0;
          if (cnt < DEPTH_V) begin
            ram_we = 1'b1;
            cnt_d  = cnt + 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end else if (gap == GAP_LAST) begin
          len_d   = cnt;
          rptr_d  = '0;
          tcnt_d  = '0;
          state_d = ST_TURN;
        end else begin
          gap_d = gap + 1'b1;
        end
      end
      ST_TURN: begin
        if (tcnt == TURN_LAST) state_d = ST_LOAD;
        else                   tcnt_d  = tcnt + 1'b1;
      end
      ST_LOAD: begin
        if (!ld_wait) begin
          ld_wait_d = 1'b1;
        end else begin
          tx_data_d = ram_rdata;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.rs485_tx_idle) begin
          tx_en_d = 1'b1;
          rptr_d  = rptr + 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!bus.rs485_tx_idle) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (bus.rs485_tx_idle) begin
          if (rptr == frame_len) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Received bytes while the bus is ours are dropped and flagged.
    if (bus.rs485_rx_valid &&
        (state inside {ST_TURN, ST_LOAD, ST_SEND, ST_WAIT_BUSY, ST_WAIT_IDLE}))
      col_d = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Counters, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      rptr       <= '0;
      gap        <= '0;
      tcnt       <= '0;
      frame_len  <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      collision  <= 1'b0;
      ld_wait    <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      rptr       <= rptr_d;
      gap        <= gap_d;
      tcnt       <= tcnt_d;
      frame_len  <= len_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      frame_done <= done_d;
      overflow   <= ov_d;
      collision  <= col_d;
      ld_wait    <= ld_wait_d;
    end
  end

  assign bus.rs485_tx_data = tx_data_q;
  assign bus.rs485_tx_en   = tx_en_q;
  assign busy              = (state != ST_IDLE);
  assign state_dbg         = state;

endmodule

// File: tb/tb_rs485_frame_echo.sv
// Directed testbench for rs485_frame_echo with a behavioural transmitter.
module tb_rs485_frame_echo;
  import rs485_pkg::*;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 6;
  localparam int GAP     = 560;
  localparam int TURN    = 32;
  localparam int TX_CHAR = 16;
  // Last rx byte sample -> tx_en visible: GAP close + TURN + 2 LOAD + 1 SEND.
  localparam int LATENCY = GAP + TURN + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rs485_frame_echo_if #(.DATA_W(DATA_W)) bus ();

  logic [ADDR_W:0] frame_len;
  logic            frame_done, overflow, collision, busy;
  state_t          state_dbg;

  rs485_frame_echo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAP_TICKS(GAP), .TURN_TICKS(TURN), .GAP_W(12)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .overflow   (overflow),
    .collision  (collision),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int last_rx_cyc = 0;
  int first_en_cyc = 0;
  bit first_en_pending = 1'b0;
  bit tx_hold = 1'b0;
  int tx_busy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transmitter model and tx/done monitor, sampled on the falling edge.
  initial begin
    bus.rs485_tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rs485_tx_en === 1'b1) begin
        en_cnt++;
        if (first_en_pending) begin
          first_en_cyc = cyc;
          first_en_pending = 1'b0;
        end
        check("idle_at_tx_en", bus.rs485_tx_idle, 1);
        check("echo_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("echo_byte", bus.rs485_tx_data, exp_q.pop_front());
        tx_busy = TX_CHAR;
      end
      if (tx_busy > 0) tx_busy--;
      bus.rs485_tx_idle = (tx_busy == 0) && !tx_hold;
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic rx_byte(input logic [DATA_W-1:0] b);
    bus.rs485_rx_data  = b;
    bus.rs485_rx_valid = 1'b1;
    @(posedge clk);
    last_rx_cyc = cyc + 1;
    #1;
    last_rx_cyc = cyc;
    bus.rs485_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input state_t s, input int budget);
    int n = 0;
    while (state_dbg != s && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, state_dbg, s);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, done_cnt - start, 1);
    check({tag, "_all_echoed"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en0;
    int n;
    logic [DATA_W-1:0] b;
    bus.rs485_rx_data  = '0;
    bus.rs485_rx_valid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", bus.rs485_tx_en, 0);
    check("rst_tx_data", bus.rs485_tx_data, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_collision", collision, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset_n = 1'b1;
    idle(2);

    // Three-byte echo with latency measurement.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    first_en_pending = 1'b1;
    rx_byte(8'h11); idle(160);
    rx_byte(8'h22); idle(160);
    rx_byte(8'h33);
    wait_done("f3_done", 3000);
    check("f3_latency", first_en_cyc - last_rx_cyc, LATENCY);
    check("f3_frame_len", frame_len, 3);
    check("f3_overflow", overflow, 0);
    check("f3_collision", collision, 0);

    // Exactly DEPTH bytes: no overflow.
    for (int i = 0; i < 64; i++) begin
      b = 8'(i * 7 + 3);
      exp_q.push_back(b);
      rx_byte(b); idle(3);
    end
    wait_done("f64_done", 5000);
    check("f64_frame_len", frame_len, 64);
    check("f64_overflow", overflow, 0);

    // DEPTH+2 bytes: overflow, first DEPTH echoed.
    for (int i = 0; i < 66; i++) begin
      b = 8'(8'hF0 ^ i);
      if (i < 64) exp_q.push_back(b);
      rx_byte(b); idle(3);
    end
    check("f66_overflow_early", overflow, 1);
    wait_done("f66_done", 5000);
    check("f66_frame_len", frame_len, 64);
    check("f66_overflow", overflow, 1);

    // Transmitter held busy at SEND.
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h3C);
    rx_byte(8'hC3); idle(10);
    rx_byte(8'h3C);
    tx_hold = 1'b1;
    wait_state("hold_reach_send", ST_SEND, 2000);
    en0 = en_cnt;
    idle(500);
    check("hold_state", state_dbg, ST_SEND);
    check("hold_no_tx_en", en_cnt - en0, 0);
    tx_hold = 1'b0;
    wait_done("hold_done", 3000);
    check("hold_one_en_per_byte", en_cnt - en0, 2);
    check("hold_overflow_cleared", overflow, 0);

    // Collision during TURN and WAIT_IDLE.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    rx_byte(8'h01); idle(5);
    rx_byte(8'h02);
    wait_state("col_reach_turn", ST_TURN, 2000);
    rx_byte(8'hAA);
    check("col_turn", collision, 1);
    wait_state("col_reach_wait_idle", ST_WAIT_IDLE, 2000);
    rx_byte(8'hAA);
    wait_done("col_done", 3000);
    check("col_sticky", collision, 1);
    check("col_frame_len", frame_len, 2);
    exp_q.push_back(8'h77);
    rx_byte(8'h77);
    check("col_cleared", collision, 0);
    wait_done("col_next_done", 3000);
    check("col_next_len", frame_len, 1);

    // Gap boundary: GAP-1 idle ticks keeps the frame open.
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    rx_byte(8'h61); idle(GAP - 1);
    check("gap_open", state_dbg, ST_RECV);
    rx_byte(8'h62);
    wait_done("gap_one_frame", 3000);
    check("gap_one_frame_len", frame_len, 2);
    // GAP idle ticks closes the frame.
    exp_q.push_back(8'h63);
    rx_byte(8'h63); idle(GAP);
    check("gap_closed", state_dbg, ST_TURN);
    check("gap_split_len_a", frame_len, 1);
    wait_done("gap_split_a_done", 3000);
    exp_q.push_back(8'h64);
    rx_byte(8'h64);
    wait_done("gap_split_b_done", 3000);
    check("gap_split_len_b", frame_len, 1);

    // Reset during WAIT_IDLE of byte 2.
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    rx_byte(8'h10); idle(4);
    rx_byte(8'h20); idle(4);
    rx_byte(8'h30);
    en0 = en_cnt;
    n = 0;
    while (!(en_cnt - en0 == 2 && state_dbg == ST_WAIT_IDLE) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_reach", state_dbg, ST_WAIT_IDLE);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx_en", bus.rs485_tx_en, 0);
    check("rst_mid_tx_data", bus.rs485_tx_data, 0);
    check("rst_mid_frame_len", frame_len, 0);
    check("rst_mid_frame_done", frame_done, 0);
    check("rst_mid_overflow", overflow, 0);
    check("rst_mid_collision", collision, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_echo_count", en_cnt - en0, 2);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    exp_q.push_back(8'h5A);
    en0 = en_cnt;
    rx_byte(8'h5A);
    wait_done("post_rst_done", 3000);
    check("post_rst_len", frame_len, 1);
    check("post_rst_en_count", en_cnt - en0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
